// File: rtl/microcode_pkg.sv
// Shared encodings for the microcode pipeline: next-address opcodes, sequencer
// source selects, microword field offsets (relative to the top of BA) and FSM states.
package microcode_pkg;

    typedef enum logic [2:0] {
        OP_CONT = 3'd0,
        OP_JMP  = 3'd1,
        OP_CJP  = 3'd2,
        OP_CJS  = 3'd3,
        OP_CRTN = 3'd4,
        OP_LDCT = 3'd5,
        OP_RPCT = 3'd6,
        OP_JZ   = 3'd7
    } op_t;

    localparam logic [1:0] S_UPC   = 2'b00;
    localparam logic [1:0] S_AR    = 2'b01;
    localparam logic [1:0] S_STACK = 2'b10;
    localparam logic [1:0] S_D     = 2'b11;

    // Offsets are added to AW, because BA occupies the low AW bits
    localparam int OP_OFS   = 0;
    localparam int OP_W     = 3;
    localparam int CSEL_OFS = 3;
    localparam int CSEL_W   = 3;
    localparam int CPOL_OFS = 6;
    localparam int HLT_OFS  = 7;
    localparam int CTRL_OFS = 8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/microcode_store.sv
// Microcode store: 2^AW words of DW bits, one write port and one registered read port.
// A read and write of the same address on one edge returns the old word.
module microcode_store #(
    parameter int AW = 4,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/microcode_pipeline.sv
// Am2909 consumer: fetches the microword at Y into the pipeline register, decodes
// its next-address field into sequencer controls and runs the loop counter and halt FSM.
module microcode_pipeline
    import microcode_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 24,
    parameter int NCOND = 8
) (
    input  logic                CP,
    input  logic                RST,
    input  logic [AW-1:0]       Y,
    input  logic                WE,
    input  logic [AW-1:0]       WA,
    input  logic [DW-1:0]       WD,
    input  logic [NCOND-1:0]    COND,
    input  logic                GO,
    output logic [1:0]          S,
    output logic                FE,
    output logic                PUP,
    output logic                ZERO,
    output logic                C,
    output logic [AW-1:0]       D,
    output logic [DW-AW-9:0]    CTRL,
    output logic [AW-1:0]       CNT,
    output logic                HALTED
);

    localparam logic [DW-1:0] RESET_WORD = DW'(OP_JZ) << AW;

    state_t          state;
    state_t          next_state;
    logic [DW-1:0]   store_rd;
    logic [DW-1:0]   pl;
    logic [AW-1:0]   cnt;
    logic            fetch;

    logic [AW-1:0]     ba;
    op_t               op;
    logic [CSEL_W-1:0] csel;
    logic              cpol;
    logic              hlt;
    logic              pass;

    // The store's read register is the pipeline register; the reset word overlays it
    // while in RESET so the store itself never needs a reset.
    microcode_store #(.AW(AW), .DW(DW)) u_store (
        .clk (CP),
        .we  (WE),
        .wa  (WA),
        .wd  (WD),
        .re  (fetch & RST),
        .ra  (Y),
        .rd  (store_rd)
    );

    assign pl   = (state == ST_RESET) ? RESET_WORD : store_rd;
    assign ba   = pl[AW-1:0];
    assign op   = op_t'(pl[AW+OP_OFS +: OP_W]);
    assign csel = pl[AW+CSEL_OFS +: CSEL_W];
    assign cpol = pl[AW+CPOL_OFS];
    assign hlt  = pl[AW+HLT_OFS];
    assign pass = COND[csel] ^ cpol;

    assign CTRL   = pl[DW-1:AW+CTRL_OFS];
    assign CNT    = cnt;
    assign HALTED = (state == ST_HALT);

    always_ff @(posedge CP) begin
        if (!RST) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fetch      = 1'b0;
        case (state)
            ST_RESET: begin
                next_state = ST_RUN;
                fetch      = 1'b1;
            end
            ST_RUN: begin
                if (hlt) begin
                    next_state = ST_HALT;
                end else begin
                    fetch = 1'b1;
                end
            end
            ST_HALT: begin
                if (GO) begin
                    next_state = ST_RUN;
                    fetch      = 1'b1;
                end
            end
            default: next_state = ST_RESET;
        endcase
    end

    // Halt freezes the sequencer on its uPC by dropping carry-in and ignoring OP.
    always_comb begin
        S    = S_UPC;
        FE   = 1'b1;
        PUP  = 1'b0;
        ZERO = 1'b1;
        C    = 1'b1;
        D    = ba;
        if (state == ST_HALT) begin
            C = 1'b0;
        end else begin
            case (op)
                OP_JMP:  S = S_D;
                OP_CJP:  S = pass ? S_D : S_UPC;
                OP_CJS: begin
                    if (pass) begin
                        S   = S_D;
                        FE  = 1'b0;
                        PUP = 1'b1;
                    end
                end
                OP_CRTN: begin
                    if (pass) begin
                        S  = S_STACK;
                        FE = 1'b0;
                    end
                end
                OP_RPCT: begin
                    if (cnt != '0) begin
                        S = S_D;
                    end
                end
                OP_JZ:   ZERO = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (!RST) begin
            cnt <= '0;
        end else if (state == ST_RUN) begin
            if (op == OP_LDCT) begin
                cnt <= ba;
            end else if (op == OP_RPCT && cnt != '0) begin
                cnt <= cnt - AW'(1);
            end
        end
    end

endmodule
